// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller.
//   state_e    : controller state encoding (RUN / FLUSH / FREEZE)
//   REG_AW_DEF : default register-specifier width
//   ZERO_REG   : architectural zero register (never a real hazard source)
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  localparam int REG_AW_DEF = 5;
  localparam logic [REG_AW_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating performance counter.
//   clk : rising-edge clock
//   rst : synchronous active-high clear
//   en  : count this cycle
//   cnt : current count (holds at all-ones)
module stall_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && !(&cnt_q)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the IF/ID register and PC.
// Detects load-use hazards (ID vs EX), flushes IF/ID after taken branches,
// and freezes the whole pipe while data memory is busy.
//   clk, rst               : clock, synchronous active-high reset
//   ID_rs, ID_rt, ID_uses_rt : source operands of the instruction in ID
//   EX_MemRead, EX_rt      : load in EX and its destination
//   branch_taken           : EX resolved a taken branch/jump
//   mem_busy               : data memory stall, hold everything
//   PC_Write, IF_ID_Write  : PC / IF/ID write enables
//   IF_ID_Flush            : clear IF/ID
//   ID_EX_Bubble           : force NOP into ID/EX
//   pipe_freeze            : hold all stage registers
//   timeout_err            : sticky, mem_busy lasted MEM_TIMEOUT cycles
//   stall_cnt              : stall cycle count (only with STALL_PERF_EN)
// Optional feature macro: STALL_PERF_EN (stall cycle counter).
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_uses_rt,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Bubble,
  output logic              pipe_freeze,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0]      FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX       = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_TRIP      = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;        // state to resume after FREEZE
  logic [1:0]      flush_cnt_q, flush_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            lu_hazard;
  state_e          eff_state;

  always_comb begin
    lu_hazard = EX_MemRead && (EX_rt != REG_AW'(ZERO_REG)) &&
                ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
    // On the release cycle the register still says FREEZE; act as the
    // state that was interrupted. The flush counter is simply held while
    // frozen, so it needs no separate save slot.
    eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    to_cnt_d    = '0;
    err_d       = err_q;

    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    pipe_freeze  = 1'b0;
    // Raised during the busy cycle that reaches the limit, then sticky.
    timeout_err  = err_q || (mem_busy && (to_cnt_q >= TO_TRIP));

    if (rst) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      timeout_err  = 1'b0;
      state_d      = ST_RUN;
      ret_d        = ST_RUN;
      flush_cnt_d  = '0;
      err_d        = 1'b0;
    end else if (mem_busy) begin
      // A coincident branch_taken is dropped; EX reissues it after release.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      pipe_freeze = 1'b1;
      if (state_q != ST_FREEZE) ret_d = state_q;
      state_d  = ST_FREEZE;
      to_cnt_d = (to_cnt_q == TO_MAX) ? TO_MAX : to_cnt_q + TO_W'(1);
      if (to_cnt_q >= TO_TRIP) err_d = 1'b1;
    end else if (branch_taken || (eff_state == ST_FLUSH)) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      if (branch_taken) begin
        // Newest branch restarts the flush window.
        state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        flush_cnt_d = (FLUSH_CYCLES > 1) ? FLUSH_RELOAD : 2'd0;
      end else begin
        flush_cnt_d = flush_cnt_q - 2'd1;
        state_d     = (flush_cnt_q == 2'd1) ? ST_RUN : ST_FLUSH;
      end
    end else begin
      state_d = ST_RUN;
      if (lu_hazard) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      flush_cnt_q <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef STALL_PERF_EN
  stall_perf_counter #(.W(CNT_W)) u_perf (
    .clk (clk),
    .rst (rst),
    .en  (!rst && !PC_Write),
    .cnt (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int MT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
  logic       ID_uses_rt = 1'b0, EX_MemRead = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;

  logic [1:0] pcw, ifw, ifl, bub, frz, terr;
  logic [31:0] scnt0, scnt1;

  always #5 clk = ~clk;

  // Instance 0: 3-cycle flush window, instance 1: 2-cycle flush window.
  hazard_stall_ctrl #(.REG_AW(5), .FLUSH_CYCLES(3), .MEM_TIMEOUT(MT), .CNT_W(32)) u_fc3 (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .PC_Write(pcw[0]), .IF_ID_Write(ifw[0]), .IF_ID_Flush(ifl[0]), .ID_EX_Bubble(bub[0]),
    .pipe_freeze(frz[0]), .timeout_err(terr[0]), .stall_cnt(scnt0));

  hazard_stall_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(MT), .CNT_W(32)) u_fc2 (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .PC_Write(pcw[1]), .IF_ID_Write(ifw[1]), .IF_ID_Flush(ifl[1]), .ID_EX_Bubble(bub[1]),
    .pipe_freeze(frz[1]), .timeout_err(terr[1]), .stall_cnt(scnt1));

  // outs bit order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, pipe_freeze, timeout_err
  typedef struct packed {
    logic [1:0][5:0]  outs;
    logic [1:0][31:0] stall;
    logic             chk_stall;
    logic [15:0]      cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: remaining flush cycles per instance, busy run length,
  // sticky error, stall tally. Freezing leaves flush_left untouched.
  int flush_left[2] = '{0, 0};
  int busy_run = 0;
  bit err_m = 1'b0;
  int stall_m[2] = '{0, 0};

  function automatic int fc_of(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  task automatic step(input bit r, input bit mb, input bit br, input bit mr,
                      input logic [4:0] ert, input logic [4:0] irs,
                      input logic [4:0] irt, input bit urt);
    exp_t e;
    bit   haz;
    logic [5:0] o;
    @(posedge clk); #1;
    rst = r; mem_busy = mb; branch_taken = br; EX_MemRead = mr;
    EX_rt = ert; ID_rs = irs; ID_rt = irt; ID_uses_rt = urt;
    cyc++;

    if (r) begin
      busy_run = 0; err_m = 1'b0;
    end else if (mb) begin
      busy_run++;
      if (busy_run >= MT) err_m = 1'b1;
    end else begin
      busy_run = 0;
    end
    haz = mr && (ert != 5'd0) && ((ert == irs) || (urt && (ert == irt)));

    e = '0;
    e.chk_stall = !r;
    e.cyc = 16'(cyc);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        o = 6'b001100; flush_left[k] = 0;
      end else if (mb) begin
        o = 6'b000010;
      end else if (br) begin
        o = 6'b111100; flush_left[k] = fc_of(k) - 1;
      end else if (flush_left[k] > 0) begin
        o = 6'b111100; flush_left[k]--;
      end else if (haz) begin
        o = 6'b000100;
      end else begin
        o = 6'b110000;
      end
      o[0] = err_m;
      e.outs[k] = o;
      e.stall[k] = 32'(stall_m[k]);
      if (r) stall_m[k] = 0;
`ifdef STALL_PERF_EN
      else if (!o[5]) stall_m[k]++;
`endif
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      logic [31:0] sa;
      e = q.pop_front();
      for (int k = 0; k < 2; k++) begin
        act = {pcw[k], ifw[k], ifl[k], bub[k], frz[k], terr[k]};
        checks++;
        if (act !== e.outs[k]) begin
          errors++;
          $display("FAIL outs_fc%0d cyc %0d: got %b want %b", fc_of(k), e.cyc, act, e.outs[k]);
        end
        if (e.chk_stall) begin
          sa = (k == 0) ? scnt0 : scnt1;
          checks++;
          if (sa !== e.stall[k]) begin
            errors++;
            $display("FAIL stall_cnt_fc%0d cyc %0d: got %0d want %0d", fc_of(k), e.cyc, sa, e.stall[k]);
          end
        end
      end
    end
  end

  int burst;

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 5, 5, 0, 0);
    idle(2);
    // Load-use on rs: exactly one stall cycle
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    idle(2);
    // Load-use via rt only when rt is a source
    step(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
    step(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    // Zero register is never a hazard
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    idle(1);
    // Branch pulse, flush window; hazard during flush ignored
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    idle(4);
    // Branch then 4 busy cycles, then remaining flush cycles
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, (i == 1), 1, 5'd2, 5'd2, 5'd0, 0);
    idle(4);
    // Branch reload inside flush
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    idle(4);
    // Timeout: 20 busy cycles, sticky until reset
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Perf: 3 load-use stalls + 4 busy cycles, then reset mid-sequence
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0);
      idle(1);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Randomized traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, mb;
      r = ($urandom_range(0, 299) == 0);
      if (burst > 0) begin
        mb = 1'b1; burst--;
      end else if ($urandom_range(0, 19) == 0) begin
        mb = 1'b1; burst = $urandom_range(0, 18);
      end else begin
        mb = 1'b0;
      end
      step(r, mb, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
